// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: program RAM + PC + 2-entry prefetch FIFO streaming instructions to the CPU.
// Optional: define HALT_DETECT_EN to stop fetching on an all-zero instruction word.
`default_nettype none

module instr_fetch_unit #(
  parameter int INSTR_WIDTH = 20,
  parameter int PC_BITS     = 5,
  parameter int FIFO_DEPTH  = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [PC_BITS-1:0]     end_addr,
  input  logic                   prog_we,
  input  logic [PC_BITS-1:0]     prog_addr,
  input  logic [INSTR_WIDTH-1:0] prog_data,
  input  logic                   instr_ready,
  output logic                   instr_valid,
  output logic [INSTR_WIDTH-1:0] instr_out,
  output logic [PC_BITS-1:0]     instr_pc,
  output logic                   busy,
  output logic                   done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [2:0] DEPTH = 3'(FIFO_DEPTH);

  state_t                 state;
  logic [INSTR_WIDTH-1:0] mem [2**PC_BITS];
  logic [PC_BITS-1:0]     pc;
  logic [PC_BITS-1:0]     end_r;
  logic                   rd_valid;
  logic [PC_BITS-1:0]     rd_pc;
  logic [INSTR_WIDTH-1:0] rd_data;
  logic [INSTR_WIDTH-1:0] e1_data;
  logic [PC_BITS-1:0]     e1_pc;
  logic [1:0]             count;

  logic       pop;
  logic       push;
  logic       halt;
  logic       issue;
  logic       prog_ok;
  logic [2:0] occ;

`ifdef HALT_DETECT_EN
  assign halt = rd_valid && (rd_data == '0);
`else
  assign halt = 1'b0;
`endif

  assign instr_valid = (count != 2'd0);
  assign pop         = instr_valid && instr_ready;
  assign push        = rd_valid && !halt;
  // A pop in the same cycle frees a slot, which is what allows one instruction per cycle.
  assign occ         = 3'(count) + 3'(rd_valid) - 3'(pop);
  assign issue       = (state == RUN) && (occ < DEPTH) && !halt;
  assign prog_ok     = prog_we && ((state == IDLE) || (state == DONE));
  assign busy        = (state == RUN) || (state == DRAIN);
  assign done        = (state == DONE);

  always_ff @(posedge clk) begin
    if (prog_ok) begin
      mem[prog_addr] <= prog_data;
    end
    if (issue) begin
      rd_data <= mem[pc];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      pc        <= '0;
      end_r     <= '0;
      rd_valid  <= 1'b0;
      rd_pc     <= '0;
      e1_data   <= '0;
      e1_pc     <= '0;
      count     <= 2'd0;
      instr_out <= '0;
      instr_pc  <= '0;
    end else begin
      rd_valid <= issue;
      if (issue) begin
        rd_pc <= pc;
        pc    <= pc + PC_BITS'(1);
      end

      case (state)
        IDLE, DONE: begin
          if (start) begin
            state <= RUN;
            pc    <= '0;
            end_r <= end_addr;
          end
        end
        RUN: begin
          if (halt || (issue && (pc == end_r))) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if ((count == 2'd0) && !rd_valid) begin
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase

      // Head register drives the outputs directly, so it only moves on a pop or a push into empty.
      if (push && pop) begin
        if (count == 2'd2) begin
          instr_out <= e1_data;
          instr_pc  <= e1_pc;
          e1_data   <= rd_data;
          e1_pc     <= rd_pc;
        end else begin
          instr_out <= rd_data;
          instr_pc  <= rd_pc;
        end
      end else if (push) begin
        if (count == 2'd0) begin
          instr_out <= rd_data;
          instr_pc  <= rd_pc;
        end else begin
          e1_data <= rd_data;
          e1_pc   <= rd_pc;
        end
      end else if (pop && (count == 2'd2)) begin
        instr_out <= e1_data;
        instr_pc  <= e1_pc;
      end

      count <= count + 2'(push) - 2'(pop);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed program runs plus randomized programs/backpressure.
`default_nettype none

module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [4:0]  end_addr = '0;
  logic        prog_we = 1'b0;
  logic [4:0]  prog_addr = '0;
  logic [19:0] prog_data = '0;
  logic        instr_ready = 1'b0;
  logic        instr_valid;
  logic [19:0] instr_out;
  logic [4:0]  instr_pc;
  logic        busy;
  logic        done;

  instr_fetch_unit #(.INSTR_WIDTH(20), .PC_BITS(5), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst(rst), .start(start), .end_addr(end_addr),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .instr_ready(instr_ready), .instr_valid(instr_valid), .instr_out(instr_out),
    .instr_pc(instr_pc), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;
  int mode = 0;
  bit checking = 1'b0;

  logic [19:0] mem_m [32];
  logic [19:0] exp_d [$];
  logic [4:0]  exp_p [$];
  logic [19:0] got_d [64];
  logic [4:0]  got_p [64];
  int          got_c [64];
  int          tx_count = 0;
  int          exp_count = 0;
  bit          stall_prev = 1'b0;
  logic [19:0] stall_d;
  logic [4:0]  stall_p;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Ready pattern: 0 = always high, 1 = one cycle in four, 2 = random.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      case (mode)
        0: instr_ready = 1'b1;
        1: instr_ready = ((cyc % 4) == 0);
        default: instr_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      if (stall_prev) begin
        chk("stall_valid", 32'(instr_valid), 32'd1);
        chk("stall_hold", {7'd0, instr_pc, instr_out}, {7'd0, stall_p, stall_d});
      end
      if (instr_valid && instr_ready) begin
        if (exp_d.size() == 0) begin
          chk("extra_transfer", tx_count, exp_count);
        end else begin
          chk("xfer_data", 32'(instr_out), 32'(exp_d.pop_front()));
          chk("xfer_pc", 32'(instr_pc), 32'(exp_p.pop_front()));
        end
        if (tx_count < 64) begin
          got_d[tx_count] = instr_out;
          got_p[tx_count] = instr_pc;
          got_c[tx_count] = cyc;
        end
        tx_count++;
      end
      stall_prev = instr_valid && !instr_ready;
      stall_d    = instr_out;
      stall_p    = instr_pc;
    end
  end

  task automatic wr(input logic [4:0] a, input logic [19:0] d, input bit takes);
    @(posedge clk);
    #1;
    prog_we = 1'b1; prog_addr = a; prog_data = d;
    @(posedge clk);
    #1;
    prog_we = 1'b0;
    if (takes) mem_m[a] = d;
  endtask

  // Expected stream: addresses 0..e in order, cut at the first all-zero word when halting is enabled.
  task automatic kick(input logic [4:0] e, input int m);
    exp_d.delete();
    exp_p.delete();
    for (int a = 0; a <= int'(e); a++) begin
`ifdef HALT_DETECT_EN
      if (mem_m[a] == 20'h0) break;
`endif
      exp_d.push_back(mem_m[a]);
      exp_p.push_back(5'(a));
    end
    exp_count  = exp_d.size();
    tx_count   = 0;
    stall_prev = 1'b0;
    mode       = m;
    @(posedge clk);
    #1;
    start = 1'b1; end_addr = e; checking = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    end_addr = 5'($urandom);
  endtask

  task automatic wait_done(input string nm);
    for (int i = 0; i < 600 && !done; i++) begin
      @(posedge clk);
      #1;
    end
    chk({nm, "_done"}, 32'(done), 32'd1);
    chk({nm, "_count"}, tx_count, exp_count);
    checking = 1'b0;
  endtask

  task automatic load_basic();
    wr(5'd0, 20'h47000, 1'b1);
    wr(5'd1, 20'h53000, 1'b1);
    wr(5'd2, 20'h72001, 1'b1);
    wr(5'd3, 20'hD80F0, 1'b1);
  endtask

  initial begin
    for (int a = 0; a < 32; a++) mem_m[a] = 20'hFFFFF;
    #2 rst = 1'b1;
    #3;
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_out", 32'(instr_out), 32'd0);
    chk("rst_pc", 32'(instr_pc), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int a = 0; a < 32; a++) wr(5'(a), 20'hFFFFF, 1'b1);
    load_basic();

    // Basic stream with latency and back-to-back delivery.
    kick(5'd3, 0);
    chk("model_len", exp_count, 4);
    @(posedge clk);
    #1;
    chk("early_valid", 32'(instr_valid), 32'd0);
    @(posedge clk);
    #1;
    chk("first_valid", 32'(instr_valid), 32'd1);
    chk("first_data", 32'(instr_out), 32'h47000);
    chk("first_pc", 32'(instr_pc), 32'd0);
    wait_done("basic");
    chk("basic_last", 32'(got_d[3]), 32'hD80F0);
    chk("basic_last_pc", 32'(got_p[3]), 32'd3);
    chk("basic_b2b", got_c[3] - got_c[0], 3);

    kick(5'd3, 1);
    wait_done("backpressure");
    chk("bp_word1", 32'(got_d[1]), 32'h53000);
    chk("bp_busy", 32'(busy), 32'd0);

    // Program writes are locked out while running.
    kick(5'd3, 1);
    repeat (2) @(posedge clk);
    chk("lock_busy", 32'(busy), 32'd1);
    wr(5'd1, 20'hB80F0, 1'b0);
    wait_done("lockout");
    chk("lock_word1", 32'(got_d[1]), 32'h53000);
    wr(5'd1, 20'hB80F0, 1'b1);
    kick(5'd3, 0);
    wait_done("restart");
    chk("restart_word1", 32'(got_d[1]), 32'hB80F0);
    chk("restart_pc1", 32'(got_p[1]), 32'd1);
    wr(5'd1, 20'h53000, 1'b1);

    kick(5'd0, 0);
    wait_done("end0");
    chk("end0_n", tx_count, 1);
    chk("end0_data", 32'(got_d[0]), 32'h47000);

    wr(5'd2, 20'h00000, 1'b1);
    kick(5'd3, 0);
    wait_done("halt");
`ifdef HALT_DETECT_EN
    chk("halt_n", tx_count, 2);
`else
    chk("halt_n", tx_count, 4);
    chk("halt_zero_fwd", 32'(got_d[2]), 32'h0);
`endif
    wr(5'd2, 20'h72001, 1'b1);

    for (int a = 0; a < 32; a++) wr(5'(a), 20'($urandom) | 20'h80000, 1'b1);
    kick(5'd31, 0);
    wait_done("full");
    chk("full_n", tx_count, 32);
    chk("full_last_pc", 32'(got_p[31]), 32'd31);
    repeat (4) @(posedge clk);
    #1;
    chk("full_nowrap", 32'(instr_valid), 32'd0);
    chk("full_stay_done", 32'(done), 32'd1);

    for (int t = 0; t < 6; t++) begin
      for (int a = 0; a < 32; a++) begin
        logic [19:0] d;
        d = ($urandom_range(0, 5) == 0) ? 20'h0 : 20'($urandom);
        wr(5'(a), d, 1'b1);
      end
      kick(5'($urandom), 2);
      wait_done("random");
    end

    // Asynchronous reset between edges, then a clean re-run from address 0.
    load_basic();
    kick(5'd3, 1);
    for (int i = 0; i < 200 && tx_count < 2; i++) @(posedge clk);
    chk("mid_reached", 32'(tx_count >= 2), 32'd1);
    checking = 1'b0;
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("mid_valid", 32'(instr_valid), 32'd0);
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    kick(5'd3, 0);
    wait_done("after_reset");
    chk("after_reset_w0", 32'(got_d[0]), 32'h47000);
    chk("after_reset_w3", 32'(got_d[3]), 32'hD80F0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
